// File: rtl/uart_tx_async.sv
// UART transmitter: start, 7/8 data bits LSB-first, optional parity, one stop bit.
// Bits are timed by a 16x baud enable. Bytes come from a holding register or an external FWFT FIFO.
module uart_tx_async #(
    parameter int TX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [7:0] tx_hold_reg,
    input  logic       write_tx,
    input  logic       fifo_empty,
    output logic       fifo_read_en,
    output logic       txrdy,
    output logic       tx_busy,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state, state_next;
    logic [7:0] hold_data;
    logic       hold_full;
    logic [7:0] shift_reg;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic       cfg_bit8, cfg_parity, cfg_odd;
    logic       tx_reg, tx_next;
    logic       load, bit_end, last_data, write_ok, parity_bit;

    function automatic logic calc_parity(input logic [7:0] d, input logic b8, input logic odd);
        return (^(d & {b8, 7'h7f})) ^ odd;
    endfunction

    assign load = (state == IDLE) && ((TX_FIFO != 0) ? !fifo_empty : hold_full);
    // A write is also accepted on the cycle the held byte moves out to the shift register.
    assign write_ok     = (TX_FIFO == 0) && write_tx && (!hold_full || load);
    assign bit_end      = baud_clock && (tick_cnt == 4'd15);
    assign last_data    = (bit_idx == (cfg_bit8 ? 3'd7 : 3'd6));
    assign parity_bit   = calc_parity(shift_reg, cfg_bit8, cfg_odd);

    assign fifo_read_en = (TX_FIFO != 0) && load;
    assign txrdy        = (TX_FIFO != 0) ? 1'b1 : !hold_full;
    assign tx_busy      = (state != IDLE);
    assign tx           = tx_reg;

    always_comb begin
        state_next = state;
        tx_next    = tx_reg;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_data) begin
                        tx_next = shift_reg[bit_idx + 3'd1];
                    end else if (cfg_parity) begin
                        state_next = PARITY;
                        tx_next    = parity_bit;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_reg     <= 1'b1;
            tick_cnt   <= 4'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            cfg_bit8   <= 1'b0;
            cfg_parity <= 1'b0;
            cfg_odd    <= 1'b0;
        end else begin
            state  <= state_next;
            tx_reg <= tx_next;
            if (load) begin
                tick_cnt   <= 4'd0;
                bit_idx    <= 3'd0;
                shift_reg  <= (TX_FIFO != 0) ? tx_hold_reg : hold_data;
                cfg_bit8   <= bit8;
                cfg_parity <= parity_en;
                cfg_odd    <= odd_n_even;
            end else if (baud_clock) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= 8'd0;
            hold_full <= 1'b0;
        end else if (write_ok) begin
            hold_data <= tx_hold_reg;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_async.sv
// Directed bench for uart_tx_async: one holding-register instance and one FIFO-fed instance.
// Serial frames are sampled mid-bit and compared with hand-derived bit sequences.
module tb_uart_tx_async;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_clock = 1'b0;
    logic       bit8, parity_en, odd_n_even;
    logic [7:0] tx_hold_reg;
    logic       write_tx;
    logic       fifo_read_en0, txrdy0, tx_busy0, tx0;
    logic       fifo_read_en1, txrdy1, tx_busy1, tx1;

    logic [7:0] mem [4];
    logic [2:0] rd_ptr;
    logic [2:0] wr_cnt;
    logic [7:0] fifo_head;
    logic       fifo_empty1;
    int         n_pulse = 0;
    int         n_viol  = 0;
    logic       prev_rd = 1'b0;
    logic [1:0] bcnt = 2'd0;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_async #(.TX_FIFO(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .tx_hold_reg(tx_hold_reg), .write_tx(write_tx), .fifo_empty(1'b1),
        .fifo_read_en(fifo_read_en0), .txrdy(txrdy0), .tx_busy(tx_busy0), .tx(tx0)
    );

    uart_tx_async #(.TX_FIFO(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .tx_hold_reg(fifo_head), .write_tx(write_tx), .fifo_empty(fifo_empty1),
        .fifo_read_en(fifo_read_en1), .txrdy(txrdy1), .tx_busy(tx_busy1), .tx(tx1)
    );

    always #5 clk = ~clk;

    // 16x enable: one pulse every 4 clocks, so one bit lasts 64 clocks.
    always @(negedge clk) begin
        bcnt       = bcnt + 2'd1;
        baud_clock = (bcnt == 2'd0);
    end

    assign fifo_head   = mem[rd_ptr[1:0]];
    assign fifo_empty1 = (rd_ptr >= wr_cnt);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_ptr <= 3'd0;
        else if (fifo_read_en1) rd_ptr <= rd_ptr + 3'd1;
    end

    always @(negedge clk) begin
        if (fifo_read_en1) n_pulse <= n_pulse + 1;
        if (fifo_read_en1 && (prev_rd || tx_busy1)) n_viol <= n_viol + 1;
        prev_rd <= fifo_read_en1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic txv(input logic sel);
        return sel ? tx1 : tx0;
    endfunction

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        tx_hold_reg = b;
        write_tx    = 1'b1;
        @(negedge clk);
        write_tx    = 1'b0;
    endtask

    // bits[i] is the i-th bit on the line, starting with the start bit.
    task automatic rx_frame(input logic sel, input logic [10:0] bits, input int nbits, input string tag);
        int t = 0;
        while (txv(sel) !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            return;
        end
        repeat (32) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) repeat (64) @(negedge clk);
            check($sformatf("%s_b%0d", tag, i), {31'd0, txv(sel)}, {31'd0, bits[i]});
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        bit8        = 1'b1;
        parity_en   = 1'b0;
        odd_n_even  = 1'b0;
        tx_hold_reg = 8'h00;
        write_tx    = 1'b0;
        wr_cnt      = 3'd0;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_txrdy", {31'd0, txrdy0}, 32'd1);
        check("rst_busy", {31'd0, tx_busy0}, 32'd0);
        check("rst_rden", {31'd0, fifo_read_en1}, 32'd0);
        check("rst_txrdy_fifo", {31'd0, txrdy1}, 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1, 0xA5
        wr(8'hA5);
        check("a5_txrdy_low", {31'd0, txrdy0}, 32'd0);
        check("a5_idle_busy", {31'd0, tx_busy0}, 32'd0);
        @(negedge clk);
        check("a5_txrdy_back", {31'd0, txrdy0}, 32'd1);
        check("a5_busy", {31'd0, tx_busy0}, 32'd1);
        check("a5_start", {31'd0, tx0}, 32'd0);
        rx_frame(1'b0, 11'b00_1101001010, 10, "a5");
        repeat (40) @(negedge clk);
        check("a5_done_busy", {31'd0, tx_busy0}, 32'd0);

        // 7 data bits, odd parity, 0x83
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
        wr(8'h83);
        rx_frame(1'b0, 11'b0_1100000110, 10, "o7_83");
        repeat (40) @(negedge clk);
        check("o7_idle_tx", {31'd0, tx0}, 32'd1);

        // 8 data bits, even parity, second byte buffered, third write dropped
        bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
        wr(8'h0F);
        fork
            rx_frame(1'b0, 11'b10000011110, 11, "e8_0f");
            begin
                repeat (100) @(negedge clk);
                wr(8'hF0);
                check("dbl_txrdy_full", {31'd0, txrdy0}, 32'd0);
                repeat (50) @(negedge clk);
                wr(8'h77);
                repeat (300) @(negedge clk);
                check("dbl_txrdy_held", {31'd0, txrdy0}, 32'd0);
            end
        join
        rx_frame(1'b0, 11'b10111100000, 11, "e8_f0");
        check("dbl_txrdy_free", {31'd0, txrdy0}, 32'd1);
        repeat (80) @(negedge clk);
        check("dbl_no_third", {31'd0, tx_busy0}, 32'd0);

        // Format change mid-frame only takes effect on the next load
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        wr(8'hC3);
        fork
            rx_frame(1'b0, 11'b0_1110000110, 10, "cfg_c3");
            begin
                repeat (200) @(negedge clk);
                bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
            end
        join
        repeat (40) @(negedge clk);
        wr(8'h81);
        rx_frame(1'b0, 11'b0_1000000010, 10, "cfg_81");
        repeat (40) @(negedge clk);

        // Reset during DATA bit 3 with a second byte held
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        wr(8'h3C);
        repeat (290) @(negedge clk);
        wr(8'h99);
        check("mid_txrdy_full", {31'd0, txrdy0}, 32'd0);
        check("mid_busy", {31'd0, tx_busy0}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx0}, 32'd1);
        check("mid_rst_txrdy", {31'd0, txrdy0}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_no_leftover_tx", {31'd0, tx0}, 32'd1);
        check("mid_no_leftover_busy", {31'd0, tx_busy0}, 32'd0);
        wr(8'h55);
        rx_frame(1'b0, 11'b0_1010101010, 10, "post_55");
        repeat (40) @(negedge clk);

        // FIFO-fed instance, three entries
        wr_cnt = 3'd3;
        rx_frame(1'b1, 11'b0_1000000010, 10, "ff_01");
        rx_frame(1'b1, 11'b0_1000000100, 10, "ff_02");
        rx_frame(1'b1, 11'b0_1000000110, 10, "ff_03");
        repeat (100) @(negedge clk);
        check("ff_pulses", n_pulse, 32'd3);
        check("ff_pulse_rules", n_viol, 32'd0);
        check("ff_idle_busy", {31'd0, tx_busy1}, 32'd0);
        check("ff_txrdy", {31'd0, txrdy1}, 32'd1);
        check("ff_rden0", {31'd0, fifo_read_en0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_async.md
# uart_tx_async

Asynchronous UART transmitter for the CoreUARTapb UART core. It is the transmit-side counterpart of the core's receiver and uses the same 16x `baud_clock` enable and the same character-format controls (`bit8`, `parity_en`, `odd_n_even`). It takes bytes either from a single holding register (written by the APB register block) or from an external first-word-fall-through FIFO. It serialises each byte LSB-first as start, data, optional parity and one stop bit on `tx`.

## Interface
- `TX_FIFO`, default 0: 0 = internal holding register loaded by `write_tx`; 1 = data popped from external FWFT FIFO via `fifo_read_en`.
- `clk` in 1: core clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `baud_clock` in 1: one-`clk` pulse at 16x baud rate.
- `bit8` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `parity_en` in 1: 1 = append parity bit.
- `odd_n_even` in 1: 1 = odd parity, 0 = even parity.
- `tx_hold_reg` in 8: data byte; write data (`TX_FIFO`=0) or FIFO head (`TX_FIFO`=1).
- `write_tx` in 1: one-`clk` write strobe (`TX_FIFO`=0 only; ignored otherwise).
- `fifo_empty` in 1: external FIFO empty (`TX_FIFO`=1 only).
- `fifo_read_en` out 1: one-`clk` pop pulse to external FIFO; constant 0 when `TX_FIFO`=0.
- `txrdy` out 1: holding register empty, can accept `write_tx`; constant 1 when `TX_FIFO`=1.
- `tx_busy` out 1: frame in progress (state ≠ IDLE).
- `tx` out 1: serial output, registered, idle high.

## Operation
- **Reset values:**
  - `tx`=1, `txrdy`=1, `tx_busy`=0, `fifo_read_en`=0.
  - State IDLE, holding register and flag cleared, counters 0.
- **Holding register (`TX_FIFO`=0):**
  - `write_tx`=1 with `txrdy`=1: capture `tx_hold_reg` and set full; `txrdy`=0 from the next edge.
  - `write_tx` while `txrdy`=0: ignored, contents unchanged.
- **States:** IDLE, START, DATA, PARITY, STOP (3-bit encoding; unused codes return to IDLE).
- **IDLE exit:**
  - `TX_FIFO`=0: on any `clk` with holding full, load the shift register, clear full (`txrdy`=1 next edge), go to START.
  - `TX_FIFO`=1: on any `clk` with `fifo_empty`=0, pulse `fifo_read_en` for that cycle, load `tx_hold_reg`, go to START.
  - The load also latches `bit8`, `parity_en` and `odd_n_even`; mid-frame changes have no effect until the next load.
- **Bit timing:**
  - 4-bit tick counter increments on each `baud_clock` and is cleared on load.
  - A bit ends on the `baud_clock` where the counter = 15, i.e. every bit lasts 16 ticks.
- **Transitions (at bit end):**
  - START → DATA.
  - DATA → DATA while bit index < N-1, where N = 8 if latched `bit8` else 7; else → PARITY if latched `parity_en`, otherwise → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- **`tx` value by state:**
  - START: 0.
  - DATA: shift-register bit[index], LSB first; in 7-bit mode bit 7 is never sent.
  - PARITY: XOR of the N sent bits, inverted if `odd_n_even`=1.
  - STOP and IDLE: 1.
- **Simultaneous write and load (`TX_FIFO`=0):** the old byte loads into the shift register and the new byte is captured; full stays 1 and `txrdy` stays 0.
- **Asynchronous reset mid-frame:** `tx` goes to 1 at once; the frame and any held byte are discarded.

## Timing
- Write at edge E (IDLE): holding full at E; load at E+1; `tx`=0 and `tx_busy`=1 after E+1.
- Frame length: (1 + N + P + 1) × 16 `baud_clock` ticks, where P = 1 if `parity_en` else 0. That gives 9 to 11 bit times.
- `tx` changes only on the load edge or on a bit-ending `baud_clock` edge; no glitches.
- Back-to-back frames: with data pending at STOP end, the next START begins 1 `clk` after IDLE entry, i.e. a stop bit of 16 ticks + 1 `clk`.
- `fifo_read_en` never asserts while `tx_busy`=1 and is never high two consecutive cycles.

## Test plan
- **Basic 8N1:** `bit8`=1, `parity_en`=0, write 0xA5 → `tx` = 0, 1,0,1,0,0,1,0,1, 1, each bit 16 ticks; `txrdy` low 1 `clk` only.
- **7-bit odd parity:** `bit8`=0, `parity_en`=1, `odd_n_even`=1, write 0x83 → data 1,1,0,0,0,0,0, parity 1, stop 1; bit 7 not sent.
- **8-bit even parity, double buffer:** write 0x0F, then 0xF0 during DATA → `txrdy`=0 until the second frame loads. Frame 1: parity 0; frame 2: parity 0; a third write during frame 1 is ignored.
- **`TX_FIFO`=1:** three entries (0x01, 0x02, 0x03), `fifo_empty` drops → exactly 3 single-cycle `fifo_read_en` pulses, one per frame, each at IDLE exit; frames sent in order.
- **Reset mid-frame:** assert `reset_n`=0 during DATA bit 3 → `tx`=1, `txrdy`=1, `tx_busy`=0 immediately. After release, a new write of 0x55 is sent cleanly.
- **Config change mid-frame:** toggle `bit8` and `parity_en` during DATA → current frame keeps its latched format; the next frame uses the new format.
